// File: rtl/id_ex_reg.sv
// D/E pipeline register: registers D-stage operands/control for E and the HI/LO unit,
// raises the mult/div structural stall, and inserts PC/BD-preserving bubbles.
// Optional bubble counter: define ID_EX_BUBBLE_CNT_EN.
module id_ex_reg #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        ext_stall,
  input  logic        hlu_busy,
  input  logic [31:0] D_pc,
  input  logic [31:0] D_instr,
  input  logic [31:0] D_rs_data,
  input  logic [31:0] D_rt_data,
  input  logic [31:0] D_ext_imm,
  input  logic        D_bd,
  input  logic [4:0]  D_exc_code,
  input  logic [3:0]  D_hlu_type,
  input  logic        D_hlu_unsigned,
  input  logic        D_hlu_dst,
  input  logic        D_hlu_write,
  input  logic        D_hlu_use,
  output logic        stall_out,
  output logic [31:0] E_pc,
  output logic [31:0] E_instr,
  output logic [31:0] E_rs_data,
  output logic [31:0] E_rt_data,
  output logic [31:0] E_ext_imm,
  output logic        E_bd,
  output logic [4:0]  E_exc_code,
  output logic [3:0]  E_hlu_type,
  output logic        E_hlu_unsigned,
  output logic        E_hlu_dst,
  output logic        E_hlu_write,
  output logic        E_valid,
  output logic [31:0] bubble_cnt
);

  localparam logic [3:0] HLU_MULT = 4'b0001;
  localparam logic [3:0] HLU_DIV  = 4'b0010;

  logic md_stall;
  logic d_faulting;

  // A mult/div sitting in E has not raised hlu_busy yet, so it must also block HI/LO users.
  assign md_stall   = D_hlu_use & (hlu_busy | (E_hlu_type == HLU_MULT) | (E_hlu_type == HLU_DIV));
  assign stall_out  = ~req & (ext_stall | md_stall);
  assign d_faulting = (D_exc_code != 5'd0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      E_pc           <= RESET_PC;
      E_instr        <= '0;
      E_rs_data      <= '0;
      E_rt_data      <= '0;
      E_ext_imm      <= '0;
      E_bd           <= 1'b0;
      E_exc_code     <= '0;
      E_hlu_type     <= '0;
      E_hlu_unsigned <= 1'b0;
      E_hlu_dst      <= 1'b0;
      E_hlu_write    <= 1'b0;
      E_valid        <= 1'b0;
    end else if (req) begin
      E_pc           <= EXC_ENTRY;
      E_instr        <= '0;
      E_rs_data      <= '0;
      E_rt_data      <= '0;
      E_ext_imm      <= '0;
      E_bd           <= 1'b0;
      E_exc_code     <= '0;
      E_hlu_type     <= '0;
      E_hlu_unsigned <= 1'b0;
      E_hlu_dst      <= 1'b0;
      E_hlu_write    <= 1'b0;
      E_valid        <= 1'b0;
    end else if (stall_out) begin
      // Bubble keeps PC/BD so an interrupt taken on it still reports the right EPC.
      E_pc           <= D_pc;
      E_instr        <= '0;
      E_rs_data      <= '0;
      E_rt_data      <= '0;
      E_ext_imm      <= '0;
      E_bd           <= D_bd;
      E_exc_code     <= '0;
      E_hlu_type     <= '0;
      E_hlu_unsigned <= 1'b0;
      E_hlu_dst      <= 1'b0;
      E_hlu_write    <= 1'b0;
      E_valid        <= 1'b0;
    end else begin
      E_pc           <= D_pc;
      E_instr        <= D_instr;
      E_rs_data      <= D_rs_data;
      E_rt_data      <= D_rt_data;
      E_ext_imm      <= D_ext_imm;
      E_bd           <= D_bd;
      E_exc_code     <= D_exc_code;
      // A faulting instruction must never start or write the HI/LO unit.
      E_hlu_type     <= d_faulting ? 4'b0000 : D_hlu_type;
      E_hlu_unsigned <= D_hlu_unsigned;
      E_hlu_dst      <= D_hlu_dst;
      E_hlu_write    <= d_faulting ? 1'b0 : D_hlu_write;
      E_valid        <= 1'b1;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else if (stall_out) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed table-driven bench for id_ex_reg: each row gives D-side inputs, the expected
// pre-edge stall_out and the expected E-side registers after the edge.
module tb_id_ex_reg;

  typedef struct {
    logic        req, ext_stall, hlu_busy;
    logic [31:0] pc, instr, rs, rt, imm;
    logic        bd;
    logic [4:0]  exc;
    logic [3:0]  htype;
    logic        hu, hd, hw, huse;
  } in_t;

  typedef struct {
    logic        stall;
    logic [31:0] pc, instr, rs, rt, imm;
    logic        bd;
    logic [4:0]  exc;
    logic [3:0]  htype;
    logic        hu, hd, hw, valid;
  } exp_t;

  localparam int NVEC = 14;

  logic        clk = 1'b0;
  logic        reset, req, ext_stall, hlu_busy;
  logic [31:0] D_pc, D_instr, D_rs_data, D_rt_data, D_ext_imm;
  logic        D_bd;
  logic [4:0]  D_exc_code;
  logic [3:0]  D_hlu_type;
  logic        D_hlu_unsigned, D_hlu_dst, D_hlu_write, D_hlu_use;
  logic        stall_out;
  logic [31:0] E_pc, E_instr, E_rs_data, E_rt_data, E_ext_imm;
  logic        E_bd;
  logic [4:0]  E_exc_code;
  logic [3:0]  E_hlu_type;
  logic        E_hlu_unsigned, E_hlu_dst, E_hlu_write, E_valid;
  logic [31:0] bubble_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cnt;

  in_t  vin [NVEC];
  exp_t vex [NVEC];

  always #5 clk = ~clk;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .req(req), .ext_stall(ext_stall), .hlu_busy(hlu_busy),
    .D_pc(D_pc), .D_instr(D_instr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
    .D_ext_imm(D_ext_imm), .D_bd(D_bd), .D_exc_code(D_exc_code), .D_hlu_type(D_hlu_type),
    .D_hlu_unsigned(D_hlu_unsigned), .D_hlu_dst(D_hlu_dst), .D_hlu_write(D_hlu_write),
    .D_hlu_use(D_hlu_use), .stall_out(stall_out), .E_pc(E_pc), .E_instr(E_instr),
    .E_rs_data(E_rs_data), .E_rt_data(E_rt_data), .E_ext_imm(E_ext_imm), .E_bd(E_bd),
    .E_exc_code(E_exc_code), .E_hlu_type(E_hlu_type), .E_hlu_unsigned(E_hlu_unsigned),
    .E_hlu_dst(E_hlu_dst), .E_hlu_write(E_hlu_write), .E_valid(E_valid),
    .bubble_cnt(bubble_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input in_t v);
    req            = v.req;
    ext_stall      = v.ext_stall;
    hlu_busy       = v.hlu_busy;
    D_pc           = v.pc;
    D_instr        = v.instr;
    D_rs_data      = v.rs;
    D_rt_data      = v.rt;
    D_ext_imm      = v.imm;
    D_bd           = v.bd;
    D_exc_code     = v.exc;
    D_hlu_type     = v.htype;
    D_hlu_unsigned = v.hu;
    D_hlu_dst      = v.hd;
    D_hlu_write    = v.hw;
    D_hlu_use      = v.huse;
  endtask

  task automatic check_e(input string tag, input exp_t x);
    check({tag, " E_pc"},           E_pc,                    x.pc);
    check({tag, " E_instr"},        E_instr,                 x.instr);
    check({tag, " E_rs_data"},      E_rs_data,               x.rs);
    check({tag, " E_rt_data"},      E_rt_data,               x.rt);
    check({tag, " E_ext_imm"},      E_ext_imm,               x.imm);
    check({tag, " E_bd"},           {31'd0, E_bd},           {31'd0, x.bd});
    check({tag, " E_exc_code"},     {27'd0, E_exc_code},     {27'd0, x.exc});
    check({tag, " E_hlu_type"},     {28'd0, E_hlu_type},     {28'd0, x.htype});
    check({tag, " E_hlu_unsigned"}, {31'd0, E_hlu_unsigned}, {31'd0, x.hu});
    check({tag, " E_hlu_dst"},      {31'd0, E_hlu_dst},      {31'd0, x.hd});
    check({tag, " E_hlu_write"},    {31'd0, E_hlu_write},    {31'd0, x.hw});
    check({tag, " E_valid"},        {31'd0, E_valid},        {31'd0, x.valid});
    check({tag, " bubble_cnt"},     bubble_cnt,              exp_cnt);
  endtask

  exp_t rst_exp;
  in_t  v_tmp;

  initial begin
    // Row fields: req ext_stall busy | pc instr rs rt imm | bd exc type | uns dst wr use
    vin[0]  = '{1'b0,1'b0,1'b0, 32'h3000,32'h01234567,32'd5,32'd7,32'h10,       1'b0,5'd0,4'd0, 1'b0,1'b0,1'b0,1'b0};
    vin[1]  = '{1'b0,1'b0,1'b0, 32'h3004,32'h00850019,32'd3,32'd4,32'h0,        1'b0,5'd0,4'd1, 1'b1,1'b0,1'b0,1'b1};
    vin[2]  = '{1'b0,1'b0,1'b0, 32'h3008,32'h00001012,32'd0,32'd0,32'h0,        1'b0,5'd0,4'd0, 1'b0,1'b0,1'b0,1'b1};
    vin[3]  = '{1'b0,1'b0,1'b1, 32'h3008,32'h00001012,32'd0,32'd0,32'h0,        1'b0,5'd0,4'd0, 1'b0,1'b0,1'b0,1'b1};
    vin[4]  = '{1'b0,1'b0,1'b0, 32'h3008,32'h00001012,32'd0,32'd0,32'h0,        1'b0,5'd0,4'd0, 1'b0,1'b0,1'b0,1'b1};
    vin[5]  = '{1'b0,1'b0,1'b0, 32'h300c,32'h00a00011,32'haa,32'd0,32'h0,       1'b0,5'd0,4'd0, 1'b0,1'b1,1'b1,1'b1};
    vin[6]  = '{1'b0,1'b0,1'b0, 32'h3014,32'h0085001b,32'd6,32'd2,32'h0,        1'b0,5'd10,4'd2, 1'b1,1'b0,1'b1,1'b1};
    vin[7]  = '{1'b0,1'b1,1'b0, 32'h3010,32'hdeadbeef,32'd9,32'd8,32'h44,       1'b1,5'd3,4'd1, 1'b1,1'b1,1'b1,1'b1};
    vin[8]  = vin[7];
    vin[9]  = vin[7];
    vin[10] = '{1'b1,1'b1,1'b0, 32'h3020,32'h11111111,32'd1,32'd2,32'h3,        1'b1,5'd4,4'd2, 1'b1,1'b1,1'b1,1'b1};
    vin[11] = '{1'b0,1'b0,1'b0, 32'h3024,32'h0085001a,32'd8,32'd2,32'h0,        1'b0,5'd0,4'd2, 1'b0,1'b0,1'b0,1'b1};
    vin[12] = '{1'b1,1'b0,1'b0, 32'h3028,32'h00001010,32'd0,32'd0,32'h0,        1'b0,5'd0,4'd0, 1'b0,1'b1,1'b0,1'b1};
    vin[13] = '{1'b0,1'b0,1'b1, 32'h302c,32'h8c220004,32'hffffffff,32'h12345678,32'h4, 1'b1,5'd0,4'd0, 1'b0,1'b0,1'b0,1'b0};

    // Expected: stall | pc instr rs rt imm | bd exc type | uns dst wr valid
    vex[0]  = '{1'b0, 32'h3000,32'h01234567,32'd5,32'd7,32'h10, 1'b0,5'd0,4'd0, 1'b0,1'b0,1'b0,1'b1};
    vex[1]  = '{1'b0, 32'h3004,32'h00850019,32'd3,32'd4,32'h0,  1'b0,5'd0,4'd1, 1'b1,1'b0,1'b0,1'b1};
    vex[2]  = '{1'b1, 32'h3008,32'h0,32'd0,32'd0,32'h0,         1'b0,5'd0,4'd0, 1'b0,1'b0,1'b0,1'b0};
    vex[3]  = vex[2];
    vex[4]  = '{1'b0, 32'h3008,32'h00001012,32'd0,32'd0,32'h0,  1'b0,5'd0,4'd0, 1'b0,1'b0,1'b0,1'b1};
    vex[5]  = '{1'b0, 32'h300c,32'h00a00011,32'haa,32'd0,32'h0, 1'b0,5'd0,4'd0, 1'b0,1'b1,1'b1,1'b1};
    vex[6]  = '{1'b0, 32'h3014,32'h0085001b,32'd6,32'd2,32'h0,  1'b0,5'd10,4'd0, 1'b1,1'b0,1'b0,1'b1};
    vex[7]  = '{1'b1, 32'h3010,32'h0,32'd0,32'd0,32'h0,         1'b1,5'd0,4'd0, 1'b0,1'b0,1'b0,1'b0};
    vex[8]  = vex[7];
    vex[9]  = vex[7];
    vex[10] = '{1'b0, 32'h4180,32'h0,32'd0,32'd0,32'h0,         1'b0,5'd0,4'd0, 1'b0,1'b0,1'b0,1'b0};
    vex[11] = '{1'b0, 32'h3024,32'h0085001a,32'd8,32'd2,32'h0,  1'b0,5'd0,4'd2, 1'b0,1'b0,1'b0,1'b1};
    vex[12] = vex[10];
    vex[13] = '{1'b0, 32'h302c,32'h8c220004,32'hffffffff,32'h12345678,32'h4, 1'b1,5'd0,4'd0, 1'b0,1'b0,1'b0,1'b1};

    rst_exp = '{1'b0, 32'h0,32'h0,32'd0,32'd0,32'h0, 1'b0,5'd0,4'd0, 1'b0,1'b0,1'b0,1'b0};

    // Reset with busy D-side inputs present
    apply(vin[7]);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_cnt = 32'd0;
    check_e("reset", rst_exp);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      apply(vin[i]);
      #1;
      check($sformatf("r%0d stall_out", i), {31'd0, stall_out}, {31'd0, vex[i].stall});
      @(posedge clk);
      #1;
`ifdef ID_EX_BUBBLE_CNT_EN
      if (vex[i].stall) exp_cnt = exp_cnt + 32'd1;
`endif
      check_e($sformatf("r%0d", i), vex[i]);
      @(negedge clk);
    end

    // Reset mid-HLU operation: load a mult, then hold a HI/LO user while busy and reset
    v_tmp = vin[1];
    apply(v_tmp);
    @(posedge clk);
    #1;
    check("pre-reset E_hlu_type", {28'd0, E_hlu_type}, 32'd1);
    @(negedge clk);
    v_tmp = vin[3];
    apply(v_tmp);
    reset = 1'b1;
    #1;
    check("mid-stall stall_out", {31'd0, stall_out}, 32'd1);
    @(posedge clk);
    #1;
    exp_cnt = 32'd0;
    check_e("mid-stall reset", rst_exp);
    @(negedge clk);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- D/E pipeline register feeding the E stage and the HI/LO multiply-divide unit (HLU).
- Registers the D-stage operands and control fields, and generates the multiply/divide structural stall.
- Inserts bubbles that keep PC and branch-delay (BD) information for precise exceptions.
- Flushes on exception/interrupt request (req).

Parameters:
- EXC_ENTRY, 32'h0000_4180: PC loaded into E on req flush.
- RESET_PC, 32'h0000_0000: E_pc value after reset.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- req  input  1  exception/interrupt flush request from CP0
- ext_stall  input  1  data-hazard stall from hazard unit
- hlu_busy  input  1  busy flag from HLU
- D_pc  input  32  D-stage PC
- D_instr  input  32  D-stage instruction
- D_rs_data  input  32  forwarded rs operand
- D_rt_data  input  32  forwarded rt operand
- D_ext_imm  input  32  extended immediate
- D_bd  input  1  D instruction sits in a delay slot
- D_exc_code  input  5  exception code from F/D (0 = none)
- D_hlu_type  input  4  4'b0001 mult, 4'b0010 div, else none
- D_hlu_unsigned  input  1  unsigned mult/div
- D_hlu_dst  input  1  1 = HI, 0 = LO (mthi/mtlo/mfhi/mflo)
- D_hlu_write  input  1  mthi/mtlo
- D_hlu_use  input  1  D instruction touches HI/LO in any way
- stall_out  output  1  freeze F/D (ext_stall | md_stall)
- E_pc, E_instr, E_rs_data, E_rt_data, E_ext_imm  output  32 each  registered copies
- E_bd  output  1  registered BD
- E_exc_code  output  5  registered exception code
- E_hlu_type  output  4  type to HLU (already gated)
- E_hlu_unsigned, E_hlu_dst, E_hlu_write  output  1 each  to HLU
- E_valid  output  1  E holds a real instruction (not a bubble/flush)
- bubble_cnt  output  32  see Optional Feature

Behaviour:
- All updates on posedge clk.
- Priority order: reset > req > stall_out > normal load.
- Reset values: E_pc = RESET_PC; every other E_* output = 0; E_valid = 0.
- md_stall, combinational: D_hlu_use & (hlu_busy | E_hlu_type==4'b0001 | E_hlu_type==4'b0010).
  - The second term covers the start cycle, where the HLU has not yet raised busy.
- stall_out = ext_stall | md_stall, combinational.
- stall_out is forced 0 while req=1, so the flush wins.
- req=1 (flush):
  - E_pc <= EXC_ENTRY.
  - All other E_* <= 0; E_valid <= 0.
- stall_out=1, req=0 (bubble):
  - E_pc <= D_pc; E_bd <= D_bd.
  - E_instr, operands, E_exc_code and all hlu fields <= 0; E_valid <= 0.
  - The bubble keeps PC/BD so an interrupt taken on the bubble reports the correct EPC.
- Normal load: every E_* <= corresponding D_* input; E_valid <= 1.
- HLU gating on load: if D_exc_code != 0, then E_hlu_type <= 0 and E_hlu_write <= 0.
  - A faulting instruction must never start or write the HLU. Other fields load normally.
- Latency: one cycle from D to E.
- The stall decision and the load happen in the same edge.
- Successive stall cycles produce successive bubbles; D is held upstream.
- A mult/div is presented to the HLU for exactly one cycle per instruction, never repeated by a stall.
- Reset asserted mid-stall or mid-HLU operation: outputs return to reset values on the next edge regardless of other inputs.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - bubble_cnt is a 32-bit register, reset to 0.
  - Increments by 1 on every edge where a bubble is inserted (stall_out=1, req=0, reset=0).
  - Wraps 32'hFFFF_FFFF -> 0.
  - Not incremented on req flushes.
- Undefined: bubble_cnt tied to 32'h0; no counter flops.

Test Plan:
- Reset, then normal load: D_pc=32'h3000, D_rs_data=5, D_rt_data=7 -> next edge E_pc=32'h3000, E_rs_data=5, E_rt_data=7, E_valid=1, stall_out=0.
- Back-to-back mult/mflo:
  - Cycle n: D_hlu_type=4'b0001 loads into E.
  - Cycle n+1: D_hlu_use=1, hlu_busy=0 -> stall_out=1 via the E-start term; bubble E_valid=0 with E_pc=mflo PC.
  - Later: stall_out stays 1 while hlu_busy=1 and releases when it drops.
- Faulting div: D_hlu_type=4'b0010, D_exc_code=5'd10 -> E_hlu_type=0, E_exc_code=10, E_valid=1.
- Req during stall: ext_stall=1 and req=1 in the same cycle -> stall_out=0; E_pc=32'h4180, E_valid=0, all other fields 0.
- Bubble PC/BD: ext_stall=1, D_pc=32'h3010, D_bd=1 -> E_pc=32'h3010, E_bd=1, E_instr=0, E_hlu_type=0; with ID_EX_BUBBLE_CNT_EN, 3 stall cycles give bubble_cnt=3.
- Reset mid-stall: hlu_busy=1, D_hlu_use=1, assert reset -> next edge all E_* = 0, E_pc=RESET_PC, bubble_cnt=0.
